sdram_port_arbiter: RTL

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter_pkg.sv | 16 +
 rtl/sdram_port_arbiter_rr_picker.sv | 27 ++
 rtl/sdram_port_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared widths and FSM encoding for the SDRAM port arbiter.
package sdram_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_REQ  = 3'd2,
        ST_XFER = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/sdram_port_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester at or after rr_ptr_i, wrapping.
module sdram_port_arbiter_rr_picker #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NPORT-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] gnt_o,
    output logic             any_req_o
);

    // Walk the ports starting at the pointer and keep the first hit.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_o     = '0;
        any_req_o = 1'b0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            idx = (32'(rr_ptr_i) + i) % NPORT;
            if (!any_req_o && req_i[IDX_W'(idx)]) begin
                any_req_o = 1'b1;
                gnt_o     = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter multiplexing NPORT burst requesters onto one SDRAM controller.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int unsigned NPORT = 4,
    parameter int unsigned TMO   = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPORT-1:0]        p_req,
    input  logic [NPORT-1:0]        p_dir,
    input  logic [NPORT*ADDR_W-1:0] p_addr,
    input  logic [NPORT*LEN_W-1:0]  p_len,
    input  logic [NPORT*DATA_W-1:0] p_wdata,
    output logic [NPORT-1:0]        p_wr_ack,
    output logic [NPORT-1:0]        p_rd_ack,
    output logic [NPORT-1:0]        p_done,
    output logic [DATA_W-1:0]       p_rdata,
    output logic                    sdram_wr_req,
    output logic                    sdram_rd_req,
    output logic [ADDR_W-1:0]       sdram_wr_addr,
    output logic [ADDR_W-1:0]       sdram_rd_addr,
    output logic [LEN_W-1:0]        sdram_wr_burst,
    output logic [LEN_W-1:0]        sdram_rd_burst,
    output logic [DATA_W-1:0]       sdram_din,
    input  logic                    sdram_wr_ack,
    input  logic                    sdram_rd_ack,
    input  logic [DATA_W-1:0]       sdram_dout,
    input  logic                    sdram_init_done,
    output logic                    tmo_err
);

    localparam int unsigned IDX_W = $clog2(NPORT);
    localparam int unsigned TMO_W = ($clog2(TMO + 1) > 10) ? $clog2(TMO + 1) : 10;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic                dir_q, dir_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                wr_req_q, wr_req_d;
    logic                rd_req_q, rd_req_d;
    logic [NPORT-1:0]    done_q, done_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                tmo_err_q, tmo_err_d;
    logic                wr_ack_q, rd_ack_q;

    logic [IDX_W-1:0]    pick_gnt;
    logic                pick_any;
    logic                match_ack;
    logic                match_ack_prev;

    logic [ADDR_W-1:0]   addr_arr  [NPORT];
    logic [LEN_W-1:0]    len_arr   [NPORT];
    logic [DATA_W-1:0]   wdata_arr [NPORT];

    // Unpack the flat per-port buses for indexed access.
    for (genvar g = 0; g < NPORT; g++) begin : g_unpack
        assign addr_arr[g]  = p_addr[g*ADDR_W +: ADDR_W];
        assign len_arr[g]   = p_len[g*LEN_W +: LEN_W];
        assign wdata_arr[g] = p_wdata[g*DATA_W +: DATA_W];
    end

    sdram_port_arbiter_rr_picker #(
        .NPORT (NPORT),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req_i     (p_req),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (pick_gnt),
        .any_req_o (pick_any)
    );

    assign match_ack      = dir_q ? sdram_wr_ack : sdram_rd_ack;
    assign match_ack_prev = dir_q ? wr_ack_q : rd_ack_q;

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            dir_q     <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            done_q    <= '0;
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            dir_q     <= dir_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            done_q    <= done_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
            wr_ack_q  <= sdram_wr_ack;
            rd_ack_q  <= sdram_rd_ack;
        end
    end

    // Next-state logic: grant, request, wait for ack edges or timeout, pulse done.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        dir_d     = dir_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        done_d    = '0;
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any && sdram_init_done) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                // A requester that vanished since IDLE leaves nothing to grant.
                if (pick_any && sdram_init_done) begin
                    gnt_d     = pick_gnt;
                    dir_d     = p_dir[pick_gnt];
                    addr_d    = addr_arr[pick_gnt];
                    len_d     = len_arr[pick_gnt];
                    wr_req_d  = p_dir[pick_gnt];
                    rd_req_d  = ~p_dir[pick_gnt];
                    tmo_cnt_d = '0;
                    state_d   = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (match_ack && !match_ack_prev) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    state_d  = ST_XFER;
                end else if (tmo_cnt_q == TMO_W'(TMO - 1)) begin
                    wr_req_d       = 1'b0;
                    rd_req_d       = 1'b0;
                    tmo_err_d      = 1'b1;
                    done_d[gnt_q]  = 1'b1;
                    state_d        = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_XFER: begin
                if (!match_ack) begin
                    done_d[gnt_q] = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                rr_ptr_d = (gnt_q == IDX_W'(NPORT - 1)) ? '0 : gnt_q + IDX_W'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller strobes routed to the granted port only while its burst is active.
    always_comb begin
        p_wr_ack = '0;
        p_rd_ack = '0;
        if (state_q == ST_REQ || state_q == ST_XFER) begin
            p_wr_ack[gnt_q] = sdram_wr_ack;
            p_rd_ack[gnt_q] = sdram_rd_ack;
        end
    end

    assign sdram_din      = wdata_arr[gnt_q];
    assign p_rdata        = sdram_dout;
    assign p_done         = done_q;
    assign tmo_err        = tmo_err_q;
    assign sdram_wr_req   = wr_req_q;
    assign sdram_rd_req   = rd_req_q;
    assign sdram_wr_addr  = addr_q;
    assign sdram_rd_addr  = addr_q;
    assign sdram_wr_burst = len_q;
    assign sdram_rd_burst = len_q;

endmodule
